// File: rtl/vec_prefetch_buf.sv
// Vector prefetch buffer: fetches a vector line by line from memory, accepts
// out-of-order responses, and serves elements on CHANNELS combinational read ports.
module vec_prefetch_buf #(
    parameter int VEC_W           = 32,
    parameter int DEPTH           = 1024,
    parameter int CHANNELS        = 16,
    parameter int LINE_BYTES      = 64,
    parameter int MAX_OUTSTANDING = 16,
    parameter int ADDR_W          = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic [ADDR_W-1:0]            vec_base_i,
    input  logic [15:0]                  vec_len_i,
    output logic                         mem_req_val_o,
    input  logic                         mem_req_rdy_i,
    output logic [ADDR_W-1:0]            mem_req_addr_o,
    output logic [5:0]                   mem_req_transid_o,
    input  logic                         mem_resp_val_i,
    input  logic [5:0]                   mem_resp_transid_i,
    input  logic [LINE_BYTES*8-1:0]      mem_resp_data_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    input  logic [CHANNELS*16-1:0]       rd_idx_i,
    output logic [CHANNELS*VEC_W-1:0]    rd_val_o,
    output logic [CHANNELS-1:0]          rd_hit_o
);
    localparam int VPL      = LINE_BYTES * 8 / VEC_W;
    localparam int LINE_LOG = $clog2(LINE_BYTES);
    localparam int EL_LOG   = $clog2(VEC_W / 8);
    localparam int VPL_LOG  = $clog2(VPL);
    localparam int AW       = $clog2(DEPTH);
    localparam int CNT_W    = 7;
    localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    baseLine_q, baseLine_d;
    logic [15:0]          off_q, off_d;
    logic [15:0]          len_q, len_d;
    logic [17:0]          numLines_q, numLines_d;
    logic [17:0]          reqIdx_q, reqIdx_d;
    logic [17:0]          respCnt_q, respCnt_d;
    logic [CNT_W-1:0]     outCnt_q, outCnt_d;
    logic [63:0]          outstanding_q, outstanding_d;
    logic                 err_q, err_d;
    logic [17:0]          tagLine_q [64];
    logic [VEC_W-1:0]     storage_q [DEPTH];
    logic [DEPTH-1:0]     valid_q;

    logic                 idleOrDone, lenOk, startOk, reqHs, respAcc;
    logic [15:0]          startOff;
    logic [17:0]          startLines;
    logic [17:0]          respLine;
    logic [23:0]          elemPos [VPL];
    logic [23:0]          elemIdx [VPL];
    logic                 wrEn [VPL];
    logic [AW-1:0]        wrAddr [VPL];
    logic                 unusedBaseBits;

    assign idleOrDone        = (state_q == IDLE) || (state_q == DONE);
    assign lenOk             = 32'(vec_len_i) <= 32'(DEPTH);
    assign startOk           = start_i && idleOrDone && lenOk;
    assign startOff          = 16'(vec_base_i[LINE_LOG-1:EL_LOG]);
    assign startLines        = (18'(startOff) + 18'(vec_len_i) + 18'(VPL - 1)) >> VPL_LOG;
    assign unusedBaseBits    = ^vec_base_i[EL_LOG-1:0];

    assign mem_req_val_o     = (state_q == FETCH) && (outCnt_q < MAX_OUT);
    assign mem_req_addr_o    = baseLine_q + (ADDR_W'(reqIdx_q) << LINE_LOG);
    assign mem_req_transid_o = reqIdx_q[5:0];
    assign reqHs             = mem_req_val_o && mem_req_rdy_i;
    assign respAcc           = mem_resp_val_i && outstanding_q[mem_resp_transid_i];
    assign respLine          = tagLine_q[mem_resp_transid_i];

    assign busy_o = (state_q == FETCH) || (state_q == DRAIN);
    assign done_o = (state_q == DONE);
    assign err_o  = err_q;

    // Map each element of an accepted line to its vector index; the leading
    // offset of line 0 and the tail past vec_len are discarded.
    always_comb begin
        for (int e = 0; e < VPL; e++) begin
            elemPos[e] = (24'(respLine) << VPL_LOG) + 24'(e);
            elemIdx[e] = elemPos[e] - 24'(off_q);
            wrEn[e]    = respAcc && (elemPos[e] >= 24'(off_q)) && (elemIdx[e] < 24'(len_q));
            wrAddr[e]  = elemIdx[e][AW-1:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        baseLine_d    = baseLine_q;
        off_d         = off_q;
        len_d         = len_q;
        numLines_d    = numLines_q;
        reqIdx_d      = reqIdx_q;
        respCnt_d     = respCnt_q;
        outCnt_d      = outCnt_q;
        outstanding_d = outstanding_q;
        err_d         = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (startOk) begin
                    baseLine_d = {vec_base_i[ADDR_W-1:LINE_LOG], LINE_LOG'(0)};
                    off_d      = startOff;
                    len_d      = vec_len_i;
                    numLines_d = startLines;
                    reqIdx_d   = '0;
                    respCnt_d  = '0;
                    state_d    = (vec_len_i == 16'd0) ? DONE : FETCH;
                end else if (start_i) begin
                    err_d = 1'b1;
                end
            end
            FETCH: if (reqHs && (reqIdx_q == numLines_q - 18'd1)) state_d = DRAIN;
            DRAIN: if (respAcc && (respCnt_q == numLines_q - 18'd1)) state_d = DONE;
            default: state_d = IDLE;
        endcase

        // Tags cannot collide: a reissued tag is always 64 lines old and retired.
        if (respAcc) begin
            respCnt_d = respCnt_q + 18'd1;
            outstanding_d[mem_resp_transid_i] = 1'b0;
        end
        if (reqHs) begin
            reqIdx_d = reqIdx_q + 18'd1;
            outstanding_d[reqIdx_q[5:0]] = 1'b1;
        end
        outCnt_d = outCnt_q + CNT_W'(reqHs) - CNT_W'(respAcc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            baseLine_q    <= '0;
            off_q         <= '0;
            len_q         <= '0;
            numLines_q    <= '0;
            reqIdx_q      <= '0;
            respCnt_q     <= '0;
            outCnt_q      <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            baseLine_q    <= baseLine_d;
            off_q         <= off_d;
            len_q         <= len_d;
            numLines_q    <= numLines_d;
            reqIdx_q      <= reqIdx_d;
            respCnt_q     <= respCnt_d;
            outCnt_q      <= outCnt_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reqHs) tagLine_q[reqIdx_q[5:0]] <= reqIdx_q;
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < VPL; e++) begin
            if (wrEn[e]) storage_q[wrAddr[e]] <= mem_resp_data_i[e*VEC_W +: VEC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || startOk) begin
            valid_q <= '0;
        end else begin
            for (int e = 0; e < VPL; e++) begin
                if (wrEn[e]) valid_q[wrAddr[e]] <= 1'b1;
            end
        end
    end

    // The length bound keeps an out-of-range index from ever reporting a hit.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_rd
        logic [15:0] idx;
        assign idx = rd_idx_i[k*16 +: 16];
        assign rd_hit_o[k] = (idx < len_q) && valid_q[idx[AW-1:0]];
        assign rd_val_o[k*VEC_W +: VEC_W] = storage_q[idx[AW-1:0]];
    end
endmodule

// File: tb/tb_vec_prefetch_buf.sv
// Self-checking bench for vec_prefetch_buf: request scoreboard, table-driven
// read checks, and hand-written credit, out-of-order and abort sequences.
module tb_vec_prefetch_buf;
    localparam int VEC_W      = 32;
    localparam int DEPTH      = 1024;
    localparam int CHANNELS   = 16;
    localparam int LINE_BYTES = 64;
    localparam int MAXO       = 4;
    localparam int ADDR_W     = 40;
    localparam logic [31:0] KEY = 32'h5A5A0000;

    logic                      clk = 1'b0;
    logic                      rstN = 1'b0;
    logic                      start = 1'b0;
    logic [ADDR_W-1:0]         vecBase = '0;
    logic [15:0]               vecLen = '0;
    logic                      memReqVal;
    logic                      memReqRdy = 1'b0;
    logic [ADDR_W-1:0]         memReqAddr;
    logic [5:0]                memReqTid;
    logic                      respVal = 1'b0;
    logic [5:0]                respTid = '0;
    logic [LINE_BYTES*8-1:0]   respData = '0;
    logic                      busy, done, err;
    logic [CHANNELS*16-1:0]    rdIdx = '0;
    logic [CHANNELS*VEC_W-1:0] rdVal;
    logic [CHANNELS-1:0]       rdHit;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [5:0]        tid;
    } req_t;

    typedef struct {
        int          phase;
        logic [15:0] idx;
        logic        hit;
        logic [31:0] val;
    } vec_t;

    req_t expQ[$];
    vec_t tbl[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   hsCount = 0;

    vec_prefetch_buf #(
        .VEC_W(VEC_W), .DEPTH(DEPTH), .CHANNELS(CHANNELS),
        .LINE_BYTES(LINE_BYTES), .MAX_OUTSTANDING(MAXO), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rstN), .start_i(start), .vec_base_i(vecBase), .vec_len_i(vecLen),
        .mem_req_val_o(memReqVal), .mem_req_rdy_i(memReqRdy), .mem_req_addr_o(memReqAddr),
        .mem_req_transid_o(memReqTid), .mem_resp_val_i(respVal), .mem_resp_transid_i(respTid),
        .mem_resp_data_i(respData), .busy_o(busy), .done_o(done), .err_o(err),
        .rd_idx_i(rdIdx), .rd_val_o(rdVal), .rd_hit_o(rdHit)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] expElem(input logic [ADDR_W-1:0] base, input int v);
        return (32'(base) + 32'(v * 4)) ^ KEY;
    endfunction

    // Sample just before the rising edge so the handshake seen is the one that edge takes.
    always @(negedge clk) begin
        #2;
        if (rstN && memReqVal && memReqRdy) begin
            hsCount++;
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected request: got addr 0x%0h tid %0d, expected none", memReqAddr, memReqTid);
            end else begin
                req_t r;
                r = expQ.pop_front();
                checkOutput("req addr", 64'(memReqAddr), 64'(r.addr));
                checkOutput("req tid", 64'(memReqTid), 64'(r.tid));
            end
        end
    end

    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [15:0] len);
        int off;
        int n;
        req_t r;
        if (len != 16'd0 && int'(len) <= DEPTH) begin
            off = int'(base[5:2]);
            n = (off + int'(len) + 15) / 16;
            for (int i = 0; i < n; i++) begin
                r.addr = {base[ADDR_W-1:6], 6'b0} + ADDR_W'(i * 64);
                r.tid  = 6'(i % 64);
                expQ.push_back(r);
            end
        end
        @(negedge clk);
        start = 1'b1; vecBase = base; vecLen = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sendResp(input logic [5:0] tid, input logic [ADDR_W-1:0] lineAddr);
        @(negedge clk);
        respVal = 1'b1;
        respTid = tid;
        for (int w = 0; w < 16; w++) respData[w*32 +: 32] = (32'(lineAddr) + 32'(w * 4)) ^ KEY;
        @(negedge clk);
        respVal = 1'b0;
    endtask

    task automatic waitHs(input int target, input int budget, input string name);
        int c = 0;
        while (hsCount < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        checkOutput(name, 64'(hsCount), 64'(target));
    endtask

    task automatic readTable(input int phase);
        foreach (tbl[i]) begin
            if (tbl[i].phase == phase) begin
                @(negedge clk);
                rdIdx = '0;
                rdIdx[15:0] = tbl[i].idx;
                #1;
                checkOutput($sformatf("rd_hit idx %0d", tbl[i].idx), 64'(rdHit[0]), 64'(tbl[i].hit));
                if (tbl[i].hit) checkOutput($sformatf("rd_val idx %0d", tbl[i].idx), 64'(rdVal[31:0]), 64'(tbl[i].val));
            end
        end
    endtask

    function automatic void addVec(input int phase, input int idx, input logic hit, input logic [31:0] val);
        vec_t v;
        v.phase = phase; v.idx = 16'(idx); v.hit = hit; v.val = val;
        tbl.push_back(v);
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish within 500000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hb;
        int c;

        addVec(1, 0,    1'b1, 32'h1000 ^ KEY);
        addVec(1, 15,   1'b1, 32'h103C ^ KEY);
        addVec(1, 16,   1'b1, 32'h1040 ^ KEY);
        addVec(1, 17,   1'b1, 32'h1044 ^ KEY);
        addVec(1, 31,   1'b1, 32'h107C ^ KEY);
        addVec(1, 32,   1'b0, 32'h0);
        addVec(1, 1000, 1'b0, 32'h0);
        addVec(2, 0,    1'b1, 32'h1008 ^ KEY);
        addVec(2, 1,    1'b1, 32'h100C ^ KEY);
        addVec(2, 13,   1'b1, 32'h103C ^ KEY);
        addVec(2, 14,   1'b1, 32'h1040 ^ KEY);
        addVec(2, 15,   1'b1, 32'h1044 ^ KEY);
        addVec(2, 16,   1'b0, 32'h0);
        addVec(2, 20,   1'b0, 32'h0);
        addVec(3, 0,    1'b1, 32'h2000 ^ KEY);
        addVec(3, 47,   1'b1, 32'h20BC ^ KEY);
        addVec(3, 48,   1'b1, 32'h20C0 ^ KEY);
        addVec(3, 63,   1'b1, 32'h20FC ^ KEY);
        addVec(3, 64,   1'b0, 32'h0);

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset err", 64'(err), 64'd0);
        checkOutput("reset req_val", 64'(memReqVal), 64'd0);
        checkOutput("reset rd_hit", 64'(rdHit), 64'd0);

        $display("[TB] oversize length");
        hb = hsCount;
        applyStimulus(40'h3000, 16'd2000);
        checkOutput("oversize err pulse", 64'(err), 64'd1);
        checkOutput("oversize busy", 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput("oversize err cleared", 64'(err), 64'd0);
        checkOutput("oversize busy later", 64'(busy), 64'd0);
        checkOutput("oversize done", 64'(done), 64'd0);

        $display("[TB] stray response in idle");
        sendResp(6'd9, 40'h1240);
        @(negedge clk);
        checkOutput("stray busy", 64'(busy), 64'd0);
        checkOutput("stray done", 64'(done), 64'd0);
        checkOutput("stray rd_hit", 64'(rdHit), 64'd0);

        $display("[TB] zero length");
        applyStimulus(40'h5000, 16'd0);
        checkOutput("zero-len done", 64'(done), 64'd1);
        checkOutput("zero-len busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("zero-len no requests", 64'(hsCount), 64'(hb));
        #1;
        checkOutput("zero-len rd_hit", 64'(rdHit[0]), 64'd0);

        $display("[TB] aligned load");
        memReqRdy = 1'b1;
        hb = hsCount;
        applyStimulus(40'h1000, 16'd32);
        checkOutput("aligned busy", 64'(busy), 64'd1);
        checkOutput("aligned done cleared", 64'(done), 64'd0);
        waitHs(hb + 2, 20, "aligned handshakes");
        sendResp(6'd0, 40'h1000);
        checkOutput("aligned done early", 64'(done), 64'd0);
        sendResp(6'd1, 40'h1040);
        checkOutput("aligned done", 64'(done), 64'd1);
        checkOutput("aligned busy end", 64'(busy), 64'd0);
        checkOutput("aligned req_val end", 64'(memReqVal), 64'd0);
        checkOutput("aligned queue empty", 64'(expQ.size()), 64'd0);
        readTable(1);

        $display("[TB] unaligned load");
        hb = hsCount;
        applyStimulus(40'h1008, 16'd16);
        waitHs(hb + 2, 20, "unaligned handshakes");
        sendResp(6'd1, 40'h1040);
        sendResp(6'd0, 40'h1000);
        checkOutput("unaligned done", 64'(done), 64'd1);
        readTable(2);

        $display("[TB] out-of-order responses");
        hb = hsCount;
        applyStimulus(40'h2000, 16'd64);
        waitHs(hb + 4, 20, "ooo handshakes");
        sendResp(6'd3, 40'h20C0);
        checkOutput("ooo done after t3", 64'(done), 64'd0);
        sendResp(6'd1, 40'h2040);
        checkOutput("ooo done after t1", 64'(done), 64'd0);
        sendResp(6'd0, 40'h2000);
        checkOutput("ooo done after t0", 64'(done), 64'd0);
        checkOutput("ooo busy before t2", 64'(busy), 64'd1);
        sendResp(6'd2, 40'h2080);
        checkOutput("ooo done after t2", 64'(done), 64'd1);
        readTable(3);
        @(negedge clk);
        for (int k = 0; k < CHANNELS; k++) rdIdx[k*16 +: 16] = 16'(k * 4 + 1);
        #1;
        for (int k = 0; k < CHANNELS; k++) begin
            checkOutput($sformatf("multi rd_hit ch %0d", k), 64'(rdHit[k]), 64'd1);
            checkOutput($sformatf("multi rd_val ch %0d", k), 64'(rdVal[k*32 +: 32]), 64'(expElem(40'h2000, k * 4 + 1)));
        end

        $display("[TB] credit limit");
        hb = hsCount;
        applyStimulus(40'h4000, 16'd256);
        waitHs(hb + 4, 20, "credit first handshakes");
        repeat (10) @(negedge clk);
        #1;
        checkOutput("credit held count", 64'(hsCount), 64'(hb + 4));
        checkOutput("credit req_val low", 64'(memReqVal), 64'd0);
        @(negedge clk);
        start = 1'b1; vecBase = 40'h9000; vecLen = 16'd8;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start ignored busy", 64'(busy), 64'd1);
        sendResp(6'd2, 40'h4080);
        waitHs(hb + 5, 20, "credit one more");
        repeat (5) @(negedge clk);
        #1;
        checkOutput("credit held after t4", 64'(hsCount), 64'(hb + 5));
        checkOutput("credit req_val low again", 64'(memReqVal), 64'd0);
        @(negedge clk);
        memReqRdy = 1'b0;
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        expQ.delete();

        $display("[TB] abort mid-fetch");
        memReqRdy = 1'b1;
        hb = hsCount;
        applyStimulus(40'h6000, 16'd128);
        c = 0;
        while (hsCount < hb + 3 && c < 30) begin
            @(negedge clk);
            c++;
        end
        memReqRdy = 1'b0;
        checkOutput("abort handshakes", 64'(hsCount), 64'(hb + 3));
        checkOutput("abort busy before", 64'(busy), 64'd1);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        checkOutput("abort err", 64'(err), 64'd0);
        checkOutput("abort req_val", 64'(memReqVal), 64'd0);
        checkOutput("abort rd_hit", 64'(rdHit), 64'd0);
        rstN = 1'b1;
        expQ.delete();
        sendResp(6'd0, 40'h6000);
        sendResp(6'd1, 40'h6040);
        sendResp(6'd2, 40'h6080);
        for (int k = 0; k < CHANNELS; k++) rdIdx[k*16 +: 16] = 16'(k);
        #1;
        checkOutput("late resp rd_hit", 64'(rdHit), 64'd0);
        checkOutput("late resp busy", 64'(busy), 64'd0);
        checkOutput("late resp done", 64'(done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
